// File: rtl/am_tx.sv
// am_tx: transmit-side alignment marker inserter for a multi-lane 64b/66b PCS.
// Every AM_PERIOD emitted slots, one slot on all lanes at once carries that
// lane's alignment marker; upstream is held off (ready_o low) during that slot.
// Optional build macro: AM_TX_BIP_EN -- when defined, a per-lane BIP
// accumulator fills the BIP3/BIP7 marker bytes; otherwise both are 8'h00.
module am_tx #(
  parameter int LANE_N    = 4,
  parameter int BLOCK_W   = 66,
  parameter int AM_PERIOD = 16384
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      valid_i,
  input  logic [LANE_N*BLOCK_W-1:0] data_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [LANE_N*BLOCK_W-1:0] data_o,
  output logic                      marker_v_o
);

  localparam int               CNT_W    = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_PERIOD - 1);

  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_nxt;
  logic                      valid_q, valid_d;
  logic                      marker_v_q, marker_v_d;
  logic [LANE_N*BLOCK_W-1:0] data_q, data_d;
  logic                      insert;

`ifdef AM_TX_BIP_EN
  logic [LANE_N-1:0][7:0]    acc_q, acc_d;
`endif

  // Fixed marker bytes per lane, packed as {M6,M5,M4,M2,M1,M0}.
  // Lanes beyond 3 have no defined marker and get zeros.
  function automatic logic [47:0] am_bytes(input int lane);
    logic [47:0] m;
    case (lane)
      0:       m = 48'hb8_89_6f_47_76_90;
      1:       m = 48'h19_3b_0f_e6_c4_f0;
      2:       m = 48'h64_9a_3a_9b_65_c5;
      3:       m = 48'hc2_86_5d_3d_79_a2;
      default: m = 48'h0;
    endcase
    return m;
  endfunction

  // Full marker block: sync header 10, then BIP7, M6..M4, BIP3, M2..M0.
  function automatic logic [BLOCK_W-1:0] am_block(input int lane,
                                                  input logic [7:0] bip3,
                                                  input logic [7:0] bip7);
    logic [47:0] m;
    m = am_bytes(lane);
    return BLOCK_W'({2'b10, bip7, m[47:24], bip3, m[23:0]});
  endfunction

`ifdef AM_TX_BIP_EN
  // Bit-interleaved parity contribution of one block: payload bit k of every
  // byte folds into bit k; the two sync-header bits fold into bits 3 and 4.
  function automatic logic [7:0] bip_f(input logic [BLOCK_W-1:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      for (int m = 0; m < 8; m++) begin
        r[k] = r[k] ^ b[8*m + k];
      end
    end
    r[3] = r[3] ^ b[64];
    r[4] = r[4] ^ b[65];
    return r;
  endfunction
`endif

  assign insert     = (cnt_q == '0);
  assign ready_o    = ~insert;
  assign valid_o    = valid_q;
  assign marker_v_o = marker_v_q;
  assign data_o     = data_q;

  assign cnt_nxt = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

  // Next-state: marker slot when the counter is at zero, else pass accepted data.
  always_comb begin
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    marker_v_d = 1'b0;
    data_d     = data_q;
`ifdef AM_TX_BIP_EN
    acc_d      = acc_q;
`endif
    if (insert) begin
      cnt_d      = cnt_nxt;
      valid_d    = 1'b1;
      marker_v_d = 1'b1;
      for (int i = 0; i < LANE_N; i++) begin
`ifdef AM_TX_BIP_EN
        // BIP3 is the parity of everything since the previous marker; the
        // accumulator restarts from this marker's own contribution.
        data_d[i*BLOCK_W +: BLOCK_W] = am_block(i, acc_q[i], ~acc_q[i]);
        acc_d[i] = bip_f(am_block(i, acc_q[i], ~acc_q[i]));
`else
        data_d[i*BLOCK_W +: BLOCK_W] = am_block(i, 8'h00, 8'h00);
`endif
      end
    end else if (valid_i) begin
      cnt_d   = cnt_nxt;
      valid_d = 1'b1;
      data_d  = data_i;
`ifdef AM_TX_BIP_EN
      for (int i = 0; i < LANE_N; i++) begin
        acc_d[i] = acc_q[i] ^ bip_f(data_i[i*BLOCK_W +: BLOCK_W]);
      end
`endif
    end
  end

  // State and output registers; reset drops outputs immediately.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      marker_v_q <= 1'b0;
      data_q     <= '0;
`ifdef AM_TX_BIP_EN
      acc_q      <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      marker_v_q <= marker_v_d;
      data_q     <= data_d;
`ifdef AM_TX_BIP_EN
      acc_q      <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_am_tx.sv
// tb_am_tx: self-checking bench for am_tx with AM_PERIOD=8. Works with or
// without AM_TX_BIP_EN defined; expectations follow the same macro.
module tb_am_tx;

  localparam int L  = 4;
  localparam int BW = 66;
  localparam int P  = 8;
  localparam int W  = L * BW;
`ifdef AM_TX_BIP_EN
  localparam bit BIP = 1'b1;
`else
  localparam bit BIP = 1'b0;
`endif

  logic         clk     = 1'b0;
  logic         nreset  = 1'b1;
  logic         valid_i = 1'b0;
  logic [W-1:0] data_i  = '0;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic         marker_v_o;

  am_tx #(.LANE_N(L), .BLOCK_W(BW), .AM_PERIOD(P)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .marker_v_o (marker_v_o)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: slots emitted since the last marker (P means a marker
  // is due), per-lane parity, and the expected held output data.
  int           since;
  logic [7:0]   macc [L];
  logic [W-1:0] exp_data;
  logic         rdy_s;

  byte unsigned am_tbl [L][6] = '{
    '{8'h90, 8'h76, 8'h47, 8'h6f, 8'h89, 8'hb8},
    '{8'hf0, 8'hc4, 8'he6, 8'h0f, 8'h3b, 8'h19},
    '{8'hc5, 8'h65, 8'h9b, 8'h3a, 8'h9a, 8'h64},
    '{8'ha2, 8'h79, 8'h3d, 8'h5d, 8'h86, 8'hc2}
  };

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         rdy;
    logic         vo;
    logic         mk;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  // Parity of a block as XOR of its eight payload bytes, plus the sync bits.
  function automatic logic [7:0] bip_model(input logic [BW-1:0] b);
    logic [7:0] x;
    x = 8'h00;
    for (int m = 0; m < 8; m++) x = x ^ b[8*m +: 8];
    x = x ^ {3'b000, b[65], b[64], 3'b000};
    return x;
  endfunction

  function automatic logic [BW-1:0] model_marker(input int lane, input logic [7:0] acc);
    logic [7:0] b3, b7;
    b3 = BIP ? acc : 8'h00;
    b7 = BIP ? ~acc : 8'h00;
    return {2'b10, b7, am_tbl[lane][5], am_tbl[lane][4], am_tbl[lane][3],
            b3, am_tbl[lane][2], am_tbl[lane][1], am_tbl[lane][0]};
  endfunction

  task automatic model_reset();
    since    = P;
    exp_data = '0;
    for (int i = 0; i < L; i++) macc[i] = 8'h00;
  endtask

  // One clock: drive inputs, check ready before the edge, check outputs after.
  task automatic cycle(input logic v, input logic [W-1:0] d, output logic rdy);
    logic          ev, em;
    logic [BW-1:0] blk;
    valid_i = v;
    data_i  = d;
    #1;
    rdy = ready_o;
    check("ready_o", W'(ready_o), W'(since != P));
    if (since == P) begin
      for (int i = 0; i < L; i++) begin
        blk = model_marker(i, macc[i]);
        exp_data[i*BW +: BW] = blk;
        macc[i] = bip_model(blk);
      end
      ev = 1'b1; em = 1'b1; since = 1;
    end else if (v) begin
      exp_data = d;
      for (int i = 0; i < L; i++) macc[i] = macc[i] ^ bip_model(d[i*BW +: BW]);
      ev = 1'b1; em = 1'b0; since++;
    end else begin
      ev = 1'b0; em = 1'b0;
    end
    @(posedge clk);
    #1;
    check("valid_o", W'(valid_o), W'(ev));
    check("marker_v_o", W'(marker_v_o), W'(em));
    check("data_o", data_o, exp_data);
  endtask

  task automatic apply_reset();
    nreset  = 1'b0;
    valid_i = 1'b0;
    #1;
    check("rst_valid_o", W'(valid_o), '0);
    check("rst_marker_v_o", W'(marker_v_o), '0);
    check("rst_data_o", data_o, '0);
    check("rst_ready_o", W'(ready_o), '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    nreset = 1'b1;
  endtask

  logic [11:0] vp, rp, vop, mkp;
  int          gap;
  bit          seen_mk;

  initial begin
    vp  = 12'b1011_1111_1011;
    rp  = 12'b1101_1111_1110;
    vop = 12'b1011_1111_1011;
    mkp = 12'b0010_0000_0001;
    for (int r = 0; r < 12; r++) begin
      tbl[r].v   = vp[r];
      tbl[r].d   = rand_w();
      tbl[r].rdy = rp[r];
      tbl[r].vo  = vop[r];
      tbl[r].mk  = mkp[r];
    end

    #2;
    apply_reset();

    // Table phase: marker first, idle slots, wrap into second marker.
    for (int r = 0; r < 12; r++) begin
      cycle(tbl[r].v, tbl[r].d, rdy_s);
      check($sformatf("tbl%0d_ready", r), W'(rdy_s), W'(tbl[r].rdy));
      check($sformatf("tbl%0d_valid", r), W'(valid_o), W'(tbl[r].vo));
      check($sformatf("tbl%0d_marker", r), W'(marker_v_o), W'(tbl[r].mk));
      if (tbl[r].vo && !tbl[r].mk)
        check($sformatf("tbl%0d_passthru", r), data_o, tbl[r].d);
      if (r == 0) begin
        check("first_marker_lane0", W'(data_o[BW-1:0]),
              BIP ? W'({2'b10, 8'hff, 24'hb8896f, 8'h00, 24'h477690})
                  : W'({2'b10, 8'h00, 24'hb8896f, 8'h00, 24'h477690}));
        check("first_marker_lane3", W'({data_o[3*BW+32 +: 24], data_o[3*BW +: 24]}),
              W'(48'hc2865d_3d79a2));
      end
    end

    // Continuous stream of 20 blocks.
    for (int n = 0; n < 20; n++) cycle(1'b1, rand_w(), rdy_s);

    // Random valid toggling; markers must be P-1 data slots apart.
    gap = 0;
    seen_mk = 1'b0;
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 1)), rand_w(), rdy_s);
      if (marker_v_o) begin
        if (seen_mk) check("marker_spacing", W'(gap), W'(P - 1));
        seen_mk = 1'b1;
        gap = 0;
      end else if (valid_o) begin
        gap++;
      end
    end

    // All-zero data: second marker parity comes only from the first marker.
    apply_reset();
    for (int n = 0; n < P + 1; n++) begin
      cycle(1'b1, '0, rdy_s);
      if (n == 0)
        check("zero_bip_m1_lane0", W'({data_o[63:56], data_o[31:24]}),
              BIP ? W'(16'hff00) : W'(16'h0000));
      if (n == P)
        check("zero_bip_m2_lane0", W'({data_o[63:56], data_o[31:24]}),
              BIP ? W'(16'hef10) : W'(16'h0000));
    end

    // Asynchronous reset in the middle of an interval (counter at 5).
    apply_reset();
    for (int n = 0; n < 5; n++) cycle(1'b1, rand_w(), rdy_s);
    #3;
    nreset = 1'b0;
    #1;
    check("midrst_valid_o", W'(valid_o), '0);
    check("midrst_marker_v_o", W'(marker_v_o), '0);
    check("midrst_data_o", data_o, '0);
    check("midrst_ready_o", W'(ready_o), '0);
    @(posedge clk);
    #1;
    model_reset();
    nreset = 1'b1;
    cycle(1'b1, rand_w(), rdy_s);
    check("postrst_marker", W'(marker_v_o), W'(1'b1));
    check("postrst_bip3_lane0", W'(data_o[31:24]), '0);
    for (int n = 0; n < 10; n++) cycle(1'b1, rand_w(), rdy_s);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
